l1_probe_responder: RTL

// - Client-side TileLink-C agent for one L1 data cache; the counterpart of the L2 coherence manager.
// - Accepts Probe on channel B and looks up the L1 tag/permission array.
// - Returns ProbeAck or ProbeAckData (8 x 128-bit beats) on C, then downgrades the line's permission.
// - Independently returns GrantAck on E for every Grant/GrantData the cache's D handler completes.

---
 rtl/tl_pkg.sv | 74 +++++++
 rtl/skdbf.sv | 46 ++++
 rtl/l1_probe_responder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// TileLink-C encodings, L1 permission/probe-state types and the probe shrink table.
package tl_pkg;

  localparam int LINE_OFF = 7;

  localparam logic [2:0] TL_OP_PROBE_ACK      = 3'd4;
  localparam logic [2:0] TL_OP_PROBE_ACK_DATA = 3'd5;
  localparam logic [2:0] TL_OP_PROBE          = 3'd6;

  localparam logic [2:0] CAP_TOT = 3'd0;
  localparam logic [2:0] CAP_TOB = 3'd1;
  localparam logic [2:0] CAP_TON = 3'd2;

  localparam logic [2:0] RPT_TTOB = 3'd0;
  localparam logic [2:0] RPT_TTON = 3'd1;
  localparam logic [2:0] RPT_BTON = 3'd2;
  localparam logic [2:0] RPT_TTOT = 3'd3;
  localparam logic [2:0] RPT_BTOB = 3'd4;
  localparam logic [2:0] RPT_NTON = 3'd5;

  typedef enum logic [1:0] {
    PERM_N  = 2'b00,
    PERM_B  = 2'b01,
    PERM_TC = 2'b10,
    PERM_TD = 2'b11
  } l1_perm_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESULT,
    ST_ACK,
    ST_DATA,
    ST_UPDATE
  } probe_state_e;

  typedef struct packed {
    logic [2:0] param;
    l1_perm_e   perm;
  } shrink_t;

  // Report param and resulting permission; Tdirty shrinks like T but lands on Tclean.
  function automatic shrink_t probe_shrink(l1_perm_e perm, logic [2:0] cap);
    shrink_t r;
    r.param = RPT_NTON;
    r.perm  = PERM_N;
    case (perm)
      PERM_TC, PERM_TD: begin
        if (cap == CAP_TOT) begin
          r.param = RPT_TTOT;
          r.perm  = PERM_TC;
        end else if (cap == CAP_TOB) begin
          r.param = RPT_TTOB;
          r.perm  = PERM_B;
        end else begin
          r.param = RPT_TTON;
          r.perm  = PERM_N;
        end
      end
      PERM_B: begin
        if (cap == CAP_TON) begin
          r.param = RPT_BTON;
          r.perm  = PERM_N;
        end else begin
          r.param = RPT_BTOB;
          r.perm  = PERM_B;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/skdbf.sv
// Two-entry skid buffer: registered push, head visible same cycle; holds head stable while
// out_rdy is low, in_rdy drops when both entries are full.
module skdbf #(
  parameter int DW = 128
) (
  input  logic          l1_clock_i,
  input  logic          l1_reset_i,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [DW-1:0] out_dat,
  input  logic          out_rdy,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push;
  logic          pop;

  assign in_rdy  = (count != 2'd2);
  assign out_vld = (count != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge l1_clock_i or posedge l1_reset_i) begin
    if (l1_reset_i) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/l1_probe_responder.sv
// L1 TileLink-C probe agent: B probe -> tag lookup -> ProbeAck/ProbeAckData on C -> perm update.
// One probe in flight; data beats pass a credit-gated skid buffer; GrantAck on E is independent.
module l1_probe_responder
  import tl_pkg::*;
#(
  parameter int TL_AW     = 29,
  parameter int SETS_LOG2 = 8
) (
  input  logic                   l1_clock_i,
  input  logic                   l1_reset_i,
  input  logic [2:0]             b_opcode_i,
  input  logic [2:0]             b_param_i,
  input  logic [3:0]             b_size_i,
  input  logic [TL_AW-1:0]       b_address_i,
  input  logic                   b_valid_i,
  output logic                   b_ready_o,
  output logic [2:0]             c_opcode_o,
  output logic [2:0]             c_param_o,
  output logic [3:0]             c_size_o,
  output logic [TL_AW-1:0]       c_address_o,
  output logic [127:0]           c_data_o,
  output logic                   c_corrupt_o,
  output logic                   c_valid_o,
  input  logic                   c_ready_i,
  output logic                   e_valid_o,
  input  logic                   e_ready_i,
  input  logic                   grant_done_i,
  output logic                   lkp_valid_o,
  output logic [TL_AW-8:0]       lkp_line_o,
  input  logic                   lkp_gnt_i,
  input  logic                   lkp_hit_i,
  input  logic [1:0]             lkp_way_i,
  input  logic [1:0]             lkp_perm_i,
  output logic                   dat_rd_en_o,
  output logic [1:0]             dat_rd_way_o,
  output logic [SETS_LOG2+2:0]   dat_rd_addr_o,
  input  logic [127:0]           dat_rd_data_i,
  output logic                   upd_valid_o,
  output logic [1:0]             upd_way_o,
  output logic [TL_AW-8:0]       upd_line_o,
  output logic [1:0]             upd_perm_o
);

  probe_state_e     state_q, state_d;
  logic [TL_AW-1:0] addr_q;
  logic [2:0]       cap_q;
  logic [1:0]       way_q;
  l1_perm_e         new_perm_q;
  logic [2:0]       c_opc_q;
  logic [2:0]       c_param_q;
  logic [3:0]       c_size_q;
  logic             do_upd_q;
  logic [3:0]       rd_beat_q;
  logic [2:0]       tx_beat_q;
  logic             rd_inflight_q;
  logic [1:0]       pend_cnt_q;

  l1_perm_e         res_perm;
  logic             res_dirty;
  logic             res_none;
  shrink_t          res_shr;
  logic             credit_ok;
  logic             c_fire;
  logic             e_fire;
  logic             skd_in_rdy;
  logic             skd_vld;
  logic [127:0]     skd_dat;
  logic [1:0]       skd_cnt;

  assign res_perm  = l1_perm_e'(lkp_perm_i);
  assign res_dirty = lkp_hit_i && (res_perm == PERM_TD);
  assign res_none  = !lkp_hit_i || (res_perm == PERM_N);
  assign res_shr   = probe_shrink(res_perm, cap_q);
  // A read may only launch if its beat is guaranteed a slot when it returns next cycle.
  assign credit_ok = ({1'b0, skd_cnt} + {2'b0, rd_inflight_q}) < 3'd2;
  assign c_fire    = c_valid_o && c_ready_i;
  assign e_fire    = e_valid_o && e_ready_i;

  skdbf #(.DW(128)) u_skdbf (
    .l1_clock_i (l1_clock_i),
    .l1_reset_i (l1_reset_i),
    .in_vld     (rd_inflight_q),
    .in_dat     (dat_rd_data_i),
    .in_rdy     (skd_in_rdy),
    .out_vld    (skd_vld),
    .out_dat    (skd_dat),
    .out_rdy    (c_ready_i && (state_q == ST_DATA)),
    .count      (skd_cnt)
  );

  always_comb begin
    state_d     = state_q;
    b_ready_o   = 1'b0;
    lkp_valid_o = 1'b0;
    c_valid_o   = 1'b0;
    dat_rd_en_o = 1'b0;
    upd_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        b_ready_o = 1'b1;
        if (b_valid_i) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        lkp_valid_o = 1'b1;
        if (lkp_gnt_i) state_d = ST_RESULT;
      end
      ST_RESULT: state_d = res_dirty ? ST_DATA : ST_ACK;
      ST_ACK: begin
        c_valid_o = 1'b1;
        if (c_ready_i) state_d = do_upd_q ? ST_UPDATE : ST_IDLE;
      end
      ST_DATA: begin
        c_valid_o   = skd_vld;
        dat_rd_en_o = (rd_beat_q != 4'd8) && credit_ok;
        if (skd_vld && c_ready_i && (tx_beat_q == 3'd7)) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        upd_valid_o = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge l1_clock_i or posedge l1_reset_i) begin
    if (l1_reset_i) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cap_q         <= 3'd0;
      way_q         <= 2'd0;
      new_perm_q    <= PERM_N;
      c_opc_q       <= 3'd0;
      c_param_q     <= 3'd0;
      c_size_q      <= 4'd0;
      do_upd_q      <= 1'b0;
      rd_beat_q     <= 4'd0;
      tx_beat_q     <= 3'd0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= dat_rd_en_o;
      if (b_valid_i && b_ready_o) begin
        addr_q <= b_address_i;
        cap_q  <= b_param_i;
      end
      if (state_q == ST_RESULT) begin
        way_q      <= lkp_way_i;
        c_size_q   <= 4'd7;
        rd_beat_q  <= 4'd0;
        tx_beat_q  <= 3'd0;
        new_perm_q <= res_shr.perm;
        if (res_none) begin
          c_opc_q   <= TL_OP_PROBE_ACK;
          c_param_q <= RPT_NTON;
          do_upd_q  <= 1'b0;
        end else begin
          c_opc_q   <= res_dirty ? TL_OP_PROBE_ACK_DATA : TL_OP_PROBE_ACK;
          c_param_q <= res_shr.param;
          do_upd_q  <= 1'b1;
        end
      end
      if (dat_rd_en_o) rd_beat_q <= rd_beat_q + 4'd1;
      if (c_fire && (state_q == ST_DATA)) tx_beat_q <= tx_beat_q + 3'd1;
    end
  end

  always_ff @(posedge l1_clock_i or posedge l1_reset_i) begin
    if (l1_reset_i) pend_cnt_q <= 2'd0;
    else            pend_cnt_q <= pend_cnt_q + 2'(grant_done_i) - 2'(e_fire);
  end

  assign e_valid_o     = (pend_cnt_q != 2'd0);
  assign c_opcode_o    = c_opc_q;
  assign c_param_o     = c_param_q;
  assign c_size_o      = c_size_q;
  assign c_address_o   = addr_q;
  assign c_data_o      = (state_q == ST_DATA) ? skd_dat : '0;
  assign c_corrupt_o   = 1'b0;
  assign lkp_line_o    = addr_q[TL_AW-1:LINE_OFF];
  assign dat_rd_way_o  = way_q;
  assign dat_rd_addr_o = {addr_q[LINE_OFF +: SETS_LOG2], rd_beat_q[2:0]};
  assign upd_way_o     = way_q;
  assign upd_line_o    = addr_q[TL_AW-1:LINE_OFF];
  assign upd_perm_o    = new_perm_q;

  a_grant_overflow: assert property (@(posedge l1_clock_i) disable iff (l1_reset_i)
    !(grant_done_i && (pend_cnt_q == 2'd3)));
  a_b_is_probe: assert property (@(posedge l1_clock_i) disable iff (l1_reset_i)
    (b_valid_i && b_ready_o) |-> (b_opcode_i == TL_OP_PROBE && b_size_i == 4'd7));
  a_skid_room: assert property (@(posedge l1_clock_i) disable iff (l1_reset_i)
    rd_inflight_q |-> skd_in_rdy);

endmodule
